// File: rtl/mandel_scheduler.sv
// mandel_scheduler: frame-level dispatcher for the Mandelbrot engine array.
// Walks the screen in raster order and hands each pixel to a free engine.
// Engines are picked round-robin among those that are ready and idle. The block
// tracks which engines hold a pixel and pulses frame_done_o once every issued
// pixel has completed.
//
// Ports:
//   clk_i, reset_i     rising-edge clock, synchronous active-high reset
//   start_i            one-cycle pulse that begins a frame (honoured only when idle)
//   engine_ready_i     per-engine result queue not full
//   engine_done_i      per-engine one-cycle completion pulse
//   dispatch_valid_o   one-hot load strobe, registered with dispatch_x_o/dispatch_y_o
//   busy_mask_o        engines currently holding a pixel
//   outstanding_o      population count of busy_mask_o
//   frame_busy_o       high from dispatch entry until frame completion
//   frame_done_o       one-cycle pulse when the last pixel of the frame has completed
//   spurious_done_o    sticky: done seen for an engine that was not busy
//
// Optional build macro MANDEL_SCHED_PERF_EN adds frame_cycles_o and stall_cycles_o
// (32-bit performance counters).
module mandel_scheduler #(
  parameter int unsigned NUM_ENGINES   = 12,
  parameter int unsigned DATA_WIDTH    = 10,
  parameter int unsigned SCREEN_WIDTH  = 640,
  parameter int unsigned SCREEN_HEIGHT = 480,
  localparam int unsigned OutW = $clog2(NUM_ENGINES + 1),
  localparam int unsigned PtrW = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   start_i,
  input  logic [NUM_ENGINES-1:0] engine_ready_i,
  input  logic [NUM_ENGINES-1:0] engine_done_i,
  output logic [NUM_ENGINES-1:0] dispatch_valid_o,
  output logic [DATA_WIDTH-1:0]  dispatch_x_o,
  output logic [DATA_WIDTH-1:0]  dispatch_y_o,
  output logic [NUM_ENGINES-1:0] busy_mask_o,
  output logic [OutW-1:0]        outstanding_o,
  output logic                   frame_busy_o,
  output logic                   frame_done_o,
  output logic                   spurious_done_o
`ifdef MANDEL_SCHED_PERF_EN
  ,
  output logic [31:0]            frame_cycles_o,
  output logic [31:0]            stall_cycles_o
`endif
);

  typedef enum logic [1:0] {StIdle, StDispatch, StDrain, StDone} state_e;

  state_e                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  x_q, x_d, y_q, y_d;
  logic [PtrW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [NUM_ENGINES-1:0] busy_q, busy_d;
  logic [OutW-1:0]        outstanding_q, outstanding_d;
  logic [NUM_ENGINES-1:0] dispatch_valid_q, dispatch_valid_d;
  logic [DATA_WIDTH-1:0]  dispatch_x_q, dispatch_x_d, dispatch_y_q, dispatch_y_d;
  logic                   frame_busy_q, frame_busy_d;
  logic                   frame_done_q, frame_done_d;
  logic                   spurious_q, spurious_d;

  logic [NUM_ENGINES-1:0] eligible;
  logic [NUM_ENGINES-1:0] grant_oh;
  logic [PtrW-1:0]        grant_idx;
  logic                   grant_found;
  logic                   grant_en;
  int unsigned            cand_idx;

  // Eligibility uses the registered mask, so a grant can never target an engine
  // whose done pulse is being consumed on the same edge.
  assign eligible = engine_ready_i & ~busy_q;

  // First eligible engine at or after rr_ptr_q, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_idx    = 0;
    for (int unsigned k = 0; k < NUM_ENGINES; k++) begin
      cand_idx = (32'(rr_ptr_q) + k) % NUM_ENGINES;
      if (!grant_found && eligible[PtrW'(cand_idx)]) begin
        grant_found = 1'b1;
        grant_idx   = PtrW'(cand_idx);
      end
    end
  end

  assign grant_en = (state_q == StDispatch) && grant_found;

  always_comb begin
    grant_oh = '0;
    if (grant_en) grant_oh[grant_idx] = 1'b1;
  end

  // Done clears first, then a grant sets: the grant wins on a collision.
  always_comb begin
    busy_d        = (busy_q & ~engine_done_i) | grant_oh;
    outstanding_d = '0;
    for (int unsigned i = 0; i < NUM_ENGINES; i++) begin
      outstanding_d = outstanding_d + OutW'(busy_d[i]);
    end
  end

  always_comb begin
    state_d          = state_q;
    x_d              = x_q;
    y_d              = y_q;
    rr_ptr_d         = rr_ptr_q;
    dispatch_valid_d = '0;
    dispatch_x_d     = dispatch_x_q;
    dispatch_y_d     = dispatch_y_q;
    frame_busy_d     = frame_busy_q;
    frame_done_d     = 1'b0;
    spurious_d       = spurious_q | (|(engine_done_i & ~busy_q));

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d      = StDispatch;
          frame_busy_d = 1'b1;
          x_d          = '0;
          y_d          = '0;
          spurious_d   = 1'b0;
        end
      end
      StDispatch: begin
        if (grant_found) begin
          dispatch_valid_d = grant_oh;
          dispatch_x_d     = x_q;
          dispatch_y_d     = y_q;
          rr_ptr_d         = (grant_idx == PtrW'(NUM_ENGINES - 1)) ? '0 : grant_idx + PtrW'(1);
          if (x_q == DATA_WIDTH'(SCREEN_WIDTH - 1)) begin
            x_d = '0;
            if (y_q == DATA_WIDTH'(SCREEN_HEIGHT - 1)) begin
              state_d = StDrain;
            end else begin
              y_d = y_q + DATA_WIDTH'(1);
            end
          end else begin
            x_d = x_q + DATA_WIDTH'(1);
          end
        end
      end
      StDrain: begin
        if (busy_d == '0) begin
          state_d      = StDone;
          frame_done_d = 1'b1;
          frame_busy_d = 1'b0;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q          <= StIdle;
      x_q              <= '0;
      y_q              <= '0;
      rr_ptr_q         <= '0;
      busy_q           <= '0;
      outstanding_q    <= '0;
      dispatch_valid_q <= '0;
      dispatch_x_q     <= '0;
      dispatch_y_q     <= '0;
      frame_busy_q     <= 1'b0;
      frame_done_q     <= 1'b0;
      spurious_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      x_q              <= x_d;
      y_q              <= y_d;
      rr_ptr_q         <= rr_ptr_d;
      busy_q           <= busy_d;
      outstanding_q    <= outstanding_d;
      dispatch_valid_q <= dispatch_valid_d;
      dispatch_x_q     <= dispatch_x_d;
      dispatch_y_q     <= dispatch_y_d;
      frame_busy_q     <= frame_busy_d;
      frame_done_q     <= frame_done_d;
      spurious_q       <= spurious_d;
    end
  end

  assign dispatch_valid_o = dispatch_valid_q;
  assign dispatch_x_o     = dispatch_x_q;
  assign dispatch_y_o     = dispatch_y_q;
  assign busy_mask_o      = busy_q;
  assign outstanding_o    = outstanding_q;
  assign frame_busy_o     = frame_busy_q;
  assign frame_done_o     = frame_done_q;
  assign spurious_done_o  = spurious_q;

`ifdef MANDEL_SCHED_PERF_EN
  logic [31:0] frame_cycles_q, stall_cycles_q;

  // Counts every non-idle cycle (dispatch, drain and the done cycle), then holds.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      frame_cycles_q <= '0;
      stall_cycles_q <= '0;
    end else if (state_q == StIdle) begin
      if (start_i) begin
        frame_cycles_q <= '0;
        stall_cycles_q <= '0;
      end
    end else begin
      frame_cycles_q <= frame_cycles_q + 32'd1;
      if (state_q == StDispatch && !grant_found) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end
    end
  end

  assign frame_cycles_o = frame_cycles_q;
  assign stall_cycles_o = stall_cycles_q;
`endif

endmodule

// File: tb/tb_mandel_scheduler.sv
// Directed testbench for mandel_scheduler with 3 engines on a 4x2 screen.
module tb_mandel_scheduler;

  localparam int unsigned NumEngines   = 3;
  localparam int unsigned DataWidth    = 10;
  localparam int unsigned ScreenWidth  = 4;
  localparam int unsigned ScreenHeight = 2;

  // Hand-traced dispatch cycles and grants (cycle 0 = start asserted).
  localparam int BasicCyc [8] = '{2, 3, 4, 9, 10, 11, 16, 17};
  localparam int BasicDv  [8] = '{1, 2, 4, 1, 2, 4, 1, 2};
  localparam int BpCyc    [8] = '{2, 3, 9, 10, 16, 17, 23, 24};
  localparam int BpDv     [8] = '{1, 4, 1, 4, 1, 4, 1, 4};

  logic                  clk_i = 1'b0;
  logic                  reset_i;
  logic                  start_i;
  logic [NumEngines-1:0] engine_ready_i;
  logic [NumEngines-1:0] engine_done_i;
  logic [NumEngines-1:0] dispatch_valid_o;
  logic [DataWidth-1:0]  dispatch_x_o;
  logic [DataWidth-1:0]  dispatch_y_o;
  logic [NumEngines-1:0] busy_mask_o;
  logic [1:0]            outstanding_o;
  logic                  frame_busy_o;
  logic                  frame_done_o;
  logic                  spurious_done_o;
`ifdef MANDEL_SCHED_PERF_EN
  logic [31:0]           frame_cycles_o;
  logic [31:0]           stall_cycles_o;
`endif

  mandel_scheduler #(
    .NUM_ENGINES  (NumEngines),
    .DATA_WIDTH   (DataWidth),
    .SCREEN_WIDTH (ScreenWidth),
    .SCREEN_HEIGHT(ScreenHeight)
  ) u_dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .start_i         (start_i),
    .engine_ready_i  (engine_ready_i),
    .engine_done_i   (engine_done_i),
    .dispatch_valid_o(dispatch_valid_o),
    .dispatch_x_o    (dispatch_x_o),
    .dispatch_y_o    (dispatch_y_o),
    .busy_mask_o     (busy_mask_o),
    .outstanding_o   (outstanding_o),
    .frame_busy_o    (frame_busy_o),
    .frame_done_o    (frame_done_o),
    .spurious_done_o (spurious_done_o)
`ifdef MANDEL_SCHED_PERF_EN
    ,
    .frame_cycles_o  (frame_cycles_o),
    .stall_cycles_o  (stall_cycles_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;
  bit auto_eng;
  int due [NumEngines];
  int log_cyc[$];
  int log_dv[$];
  int log_x[$];
  int log_y[$];
  int done_cyc[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clear_logs();
    log_cyc.delete();
    log_dv.delete();
    log_x.delete();
    log_y.delete();
    done_cyc.delete();
    for (int i = 0; i < NumEngines; i++) due[i] = -1;
  endtask

  // One clock: observe #1 after the edge, then model the engines (done 5 cycles
  // after the dispatch becomes visible).
  task automatic step();
    @(posedge clk_i);
    #1;
    cyc++;
    if (dispatch_valid_o != '0) begin
      check("dv_onehot", 32'($onehot0(dispatch_valid_o)), 32'd1);
      check("dv_sets_busy", 32'(dispatch_valid_o & ~busy_mask_o), 32'd0);
      log_cyc.push_back(cyc);
      log_dv.push_back(int'(dispatch_valid_o));
      log_x.push_back(int'(dispatch_x_o));
      log_y.push_back(int'(dispatch_y_o));
      for (int i = 0; i < NumEngines; i++) if (dispatch_valid_o[i]) due[i] = cyc + 5;
    end
    if (frame_done_o) done_cyc.push_back(cyc);
    if (auto_eng) begin
      for (int i = 0; i < NumEngines; i++) engine_done_i[i] = (due[i] == cyc);
    end
  endtask

  task automatic do_reset();
    reset_i        = 1'b1;
    start_i        = 1'b0;
    engine_done_i  = '0;
    engine_ready_i = '0;
    auto_eng       = 1'b0;
    clear_logs();
    step();
    step();
    reset_i = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_dv"}, 32'(dispatch_valid_o), 32'd0);
    check({tag, "_x"}, 32'(dispatch_x_o), 32'd0);
    check({tag, "_y"}, 32'(dispatch_y_o), 32'd0);
    check({tag, "_busy"}, 32'(busy_mask_o), 32'd0);
    check({tag, "_outst"}, 32'(outstanding_o), 32'd0);
    check({tag, "_fbusy"}, 32'(frame_busy_o), 32'd0);
    check({tag, "_fdone"}, 32'(frame_done_o), 32'd0);
    check({tag, "_spur"}, 32'(spurious_done_o), 32'd0);
  endtask

  task automatic run_frame(input logic [NumEngines-1:0] ready);
    clear_logs();
    auto_eng       = 1'b1;
    engine_ready_i = ready;
    cyc            = 0;
    start_i        = 1'b1;
    step();
    start_i = 1'b0;
    check("frame_busy_on", 32'(frame_busy_o), 32'd1);
    repeat (50) step();
    auto_eng = 1'b0;
  endtask

  task automatic check_frame(input string tag, input int ecyc[8], input int edv[8],
                             input int edone);
    check({tag, "_n_disp"}, 32'(log_cyc.size()), 32'd8);
    for (int k = 0; k < 8; k++) begin
      if (k < log_cyc.size()) begin
        check($sformatf("%s_cyc%0d", tag, k), 32'(log_cyc[k]), 32'(ecyc[k]));
        check($sformatf("%s_dv%0d", tag, k), 32'(log_dv[k]), 32'(edv[k]));
        check($sformatf("%s_x%0d", tag, k), 32'(log_x[k]), 32'(k % 4));
        check($sformatf("%s_y%0d", tag, k), 32'(log_y[k]), 32'(k / 4));
      end
    end
    check({tag, "_n_done"}, 32'(done_cyc.size()), 32'd1);
    if (done_cyc.size() > 0) check({tag, "_done_cyc"}, 32'(done_cyc[0]), 32'(edone));
    check({tag, "_busy_end"}, 32'(busy_mask_o), 32'd0);
    check({tag, "_outst_end"}, 32'(outstanding_o), 32'd0);
    check({tag, "_fbusy_end"}, 32'(frame_busy_o), 32'd0);
  endtask

  initial begin
    cyc = 0;
    do_reset();
    check_idle_outputs("reset");

    // Basic frame: all engines ready.
    run_frame(3'b111);
    check_frame("basic", BasicCyc, BasicDv, 23);
`ifdef MANDEL_SCHED_PERF_EN
    check("basic_frame_cycles", frame_cycles_o, 32'd23);
    check("basic_stall_cycles", stall_cycles_o, 32'd8);
`endif

    // Backpressure: engine 1 never ready.
    do_reset();
    run_frame(3'b101);
    check_frame("bp", BpCyc, BpDv, 30);
`ifdef MANDEL_SCHED_PERF_EN
    check("bp_frame_cycles", frame_cycles_o, 32'd30);
    check("bp_stall_cycles", stall_cycles_o, 32'd15);
`endif

    // Same-cycle completion, round-robin successor, start ignored mid-frame.
    do_reset();
    engine_ready_i = 3'b111;
    cyc            = 0;
    start_i        = 1'b1;
    step();
    start_i = 1'b0;
    step();
    step();
    step();
    check("sc_busy_full", 32'(busy_mask_o), 32'd7);
    check("sc_outst_full", 32'(outstanding_o), 32'd3);
    engine_done_i = 3'b010;
    step();
    engine_done_i = '0;
    step();
    check("sc_dv_eng1", 32'(dispatch_valid_o), 32'd2);
    check("sc_x_eng1", 32'(dispatch_x_o), 32'd3);
    check("sc_outst_3", 32'(outstanding_o), 32'd3);
    engine_done_i = 3'b101;
    step();
    engine_done_i = '0;
    check("sc_busy_two_clear", 32'(busy_mask_o), 32'd2);
    check("sc_outst_drop2", 32'(outstanding_o), 32'd1);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    check("sc_rr_successor", 32'(dispatch_valid_o), 32'd4);
    check("sc_x_after_start", 32'(dispatch_x_o), 32'd0);
    check("sc_y_after_start", 32'(dispatch_y_o), 32'd1);
    step();
    check("sc_dv_next", 32'(dispatch_valid_o), 32'd1);
    check("sc_x_next", 32'(dispatch_x_o), 32'd1);
    check("sc_y_next", 32'(dispatch_y_o), 32'd1);
    check("sc_fbusy", 32'(frame_busy_o), 32'd1);
    check("sc_no_spur", 32'(spurious_done_o), 32'd0);

    // Spurious done while idle, sticky until start.
    do_reset();
    engine_done_i = 3'b010;
    step();
    engine_done_i = '0;
    check("spur_set", 32'(spurious_done_o), 32'd1);
    check("spur_busy", 32'(busy_mask_o), 32'd0);
    step();
    check("spur_sticky", 32'(spurious_done_o), 32'd1);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    check("spur_cleared", 32'(spurious_done_o), 32'd0);
    check("spur_fbusy", 32'(frame_busy_o), 32'd1);

    // Reset after three dispatches, then a clean frame.
    do_reset();
    clear_logs();
    auto_eng       = 1'b1;
    engine_ready_i = 3'b111;
    cyc            = 0;
    start_i        = 1'b1;
    step();
    start_i = 1'b0;
    step();
    step();
    step();
    check("rst_three_disp", 32'(log_cyc.size()), 32'd3);
    reset_i = 1'b1;
    for (int i = 0; i < NumEngines; i++) due[i] = -1;
    engine_done_i = '0;
    step();
    reset_i = 1'b0;
    check_idle_outputs("rst_mid");
    step();
    check("rst_stays_idle", 32'(dispatch_valid_o), 32'd0);
    clear_logs();
    cyc     = 0;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    step();
    check("rst_restart_dv", 32'(dispatch_valid_o), 32'd1);
    check("rst_restart_x", 32'(dispatch_x_o), 32'd0);
    check("rst_restart_y", 32'(dispatch_y_o), 32'd0);
    repeat (40) step();
    check("rst_n_done", 32'(done_cyc.size()), 32'd1);
    if (done_cyc.size() > 0) check("rst_done_cyc", 32'(done_cyc[0]), 32'd23);
    auto_eng = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
